// File: rtl/axi_sram_pattern_tester_pkg.sv
// Shared types and constants for the AXI-Lite SRAM pattern tester.
//   state_t          : tester FSM states
//   AXI_RESP_OKAY    : AXI OKAY response code
//   LFSR_TAPS_8/16   : Galois (right-shift) feedback taps for maximal-length LFSRs
package axi_sram_pattern_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  // x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
  localparam logic [7:0]  LFSR_TAPS_8   = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16  = 16'hB400;

  function automatic logic [15:0] lfsr_taps(input int dw);
    return (dw == 16) ? LFSR_TAPS_16 : {8'h00, LFSR_TAPS_8};
  endfunction

endpackage

// File: rtl/axi_sram_pattern_tester_lfsr.sv
// Galois LFSR pattern source for the SRAM tester (used only when
// AXI_SRAM_PATTERN_TESTER_LFSR_EN is defined).
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_seed (a zero seed is replaced by 1, the all-zero state is a lock-up)
//   i_step       : advance one step
//   i_seed       : seed value
//   o_value      : current LFSR state
module axi_sram_pattern_tester_lfsr
  import axi_sram_pattern_tester_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [DW-1:0] i_seed,
  output logic [DW-1:0] o_value
);

  localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

  logic [DW-1:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? DW'(1) : i_seed;
    end else if (i_step) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
    end
  end

  assign o_value = r_state;

endmodule

// File: rtl/axi_sram_pattern_tester.sv
// AXI-Lite master that writes a deterministic pattern to SRAM words
// 0..ADDR_LAST, reads them back and compares, reporting pass/fail and the
// first failing word.
// Config macro: AXI_SRAM_PATTERN_TESTER_LFSR_EN selects an LFSR pattern;
// otherwise data = addr ^ PATTERN_SEED.
// Ports:
//   i_axi_clk, i_axi_reset : clock, asynchronous active-high reset
//   i_start                : 1-cycle start pulse (accepted in IDLE/DONE)
//   o_busy, o_done, o_pass : status
//   o_fail_addr/expected/actual : first failure details
//   o_axi_* / i_axi_*      : AXI-Lite master channels
//
// state      | meaning
// IDLE       | waiting for first start
// WR_ADDR    | AW and W valid, waiting for both handshakes
// WR_RESP    | waiting for write response
// RD_ADDR    | AR valid, waiting for arready
// RD_DATA    | waiting for read data, compare
// DONE       | result valid, waiting for start
module axi_sram_pattern_tester
  import axi_sram_pattern_tester_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 10,
  parameter int                        AXI_DATA_WIDTH = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LAST      = '1,
  parameter logic [7:0]                PATTERN_SEED   = 8'hA5
) (
  input  logic                      i_axi_clk,
  input  logic                      i_axi_reset,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [AXI_ADDR_WIDTH-1:0] o_fail_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_fail_expected,
  output logic [AXI_DATA_WIDTH-1:0] o_fail_actual,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic                      o_axi_awvalid,
  input  logic                      i_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] o_axi_wdata,
  output logic                      o_axi_wstrb,
  output logic                      o_axi_wvalid,
  input  logic                      i_axi_wready,
  input  logic [1:0]                i_axi_bresp,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam logic [DW-1:0] SEED = DW'(PATTERN_SEED);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_awvalid, r_wvalid, r_aw_done, r_w_done;
  logic          r_bready, r_arvalid, r_rready;
  logic          r_busy, r_done, r_pass;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_expected, r_fail_actual;

  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic          w_last, w_b_ok, w_r_ok;
  logic [DW-1:0] w_expected;

  assign w_aw_hs = r_awvalid & i_axi_awready;
  assign w_w_hs  = r_wvalid  & i_axi_wready;
  assign w_b_hs  = r_bready  & i_axi_bvalid;
  assign w_ar_hs = r_arvalid & i_axi_arready;
  assign w_r_hs  = r_rready  & i_axi_rvalid;
  assign w_last  = (r_addr == ADDR_LAST);
  assign w_b_ok  = (i_axi_bresp == AXI_RESP_OKAY);
  assign w_r_ok  = (i_axi_rresp == AXI_RESP_OKAY) && (i_axi_rdata == w_expected);

`ifdef AXI_SRAM_PATTERN_TESTER_LFSR_EN
  logic          w_lfsr_load, w_lfsr_step;
  logic [DW-1:0] w_lfsr_value;

  // Load at start and again before the read phase so reads replay the writes;
  // step only after a word has been accepted (data must stay stable until then).
  assign w_lfsr_load = (i_start && (r_state == ST_IDLE || r_state == ST_DONE))
                     || (r_state == ST_WR_RESP && w_b_hs && w_b_ok && w_last);
  assign w_lfsr_step = (r_state == ST_WR_RESP && w_b_hs && w_b_ok && !w_last)
                     || (r_state == ST_RD_DATA && w_r_hs && w_r_ok && !w_last);

  axi_sram_pattern_tester_lfsr #(.DW(DW)) u_lfsr (
    .i_clk   (i_axi_clk),
    .i_rst   (i_axi_reset),
    .i_load  (w_lfsr_load),
    .i_step  (w_lfsr_step),
    .i_seed  (SEED),
    .o_value (w_lfsr_value)
  );

  assign w_expected = w_lfsr_value;
`else
  assign w_expected = DW'(r_addr) ^ SEED;
`endif

  always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
    if (i_axi_reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_bready        <= 1'b0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_fail_addr     <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state         <= ST_WR_ADDR;
            r_addr          <= '0;
            r_awvalid       <= 1'b1;
            r_wvalid        <= 1'b1;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_addr     <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
          end
        end
        ST_WR_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_state  <= ST_WR_RESP;
            r_bready <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (!w_b_ok) begin
              r_fail_addr     <= r_addr;
              r_fail_expected <= w_expected;
              r_fail_actual   <= '0;
              r_state         <= ST_DONE;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
            end else if (w_last) begin
              r_state   <= ST_RD_ADDR;
              r_addr    <= '0;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end else begin
              r_state   <= ST_WR_ADDR;
              r_addr    <= r_addr + AW'(1);
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_r_hs) begin
            if (!w_r_ok) begin
              r_fail_addr     <= r_addr;
              r_fail_expected <= w_expected;
              r_fail_actual   <= i_axi_rdata;
              r_rready        <= 1'b0;
              r_state         <= ST_DONE;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
            end else if (w_last) begin
              r_rready <= 1'b0;
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= 1'b1;
            end else begin
              r_addr    <= r_addr + AW'(1);
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_fail_addr     = r_fail_addr;
  assign o_fail_expected = r_fail_expected;
  assign o_fail_actual   = r_fail_actual;
  assign o_axi_awaddr    = r_addr;
  assign o_axi_awvalid   = r_awvalid;
  // Data is driven only while wvalid is high so it reads as zero when idle.
  assign o_axi_wdata     = r_wvalid ? w_expected : '0;
  assign o_axi_wstrb     = 1'b1;
  assign o_axi_wvalid    = r_wvalid;
  assign o_axi_bready    = r_bready;
  assign o_axi_araddr    = r_addr;
  assign o_axi_arvalid   = r_arvalid;
  assign o_axi_rready    = r_rready;

endmodule

// File: tb/tb_axi_sram_pattern_tester.sv
`timescale 1ns/1ps
module tb_axi_sram_pattern_tester;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int N_DUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;
  always #5 clk = ~clk;

  logic          d_start[N_DUT], d_busy[N_DUT], d_done[N_DUT], d_pass[N_DUT];
  logic [AW-1:0] d_fail_addr[N_DUT], d_awaddr[N_DUT], d_araddr[N_DUT];
  logic [DW-1:0] d_fail_exp[N_DUT], d_fail_act[N_DUT], d_wdata[N_DUT];
  logic          d_awvalid[N_DUT], d_wvalid[N_DUT], d_wstrb[N_DUT], d_bready[N_DUT];
  logic          d_arvalid[N_DUT], d_rready[N_DUT];
  logic          d_awready[N_DUT], d_wready[N_DUT], d_bvalid[N_DUT], d_arready[N_DUT], d_rvalid[N_DUT];

  logic          s_awvalid, s_wvalid, s_wstrb, s_bready, s_arvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]    s_bresp, s_rresp;

  // dut 0: ADDR_LAST=0x00F, dut 1: ADDR_LAST=0, dut 2: full range
  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    assign d_start[g]   = start && (sel == g);
    assign d_awready[g] = (sel == g) && s_awready;
    assign d_wready[g]  = (sel == g) && s_wready;
    assign d_bvalid[g]  = (sel == g) && s_bvalid;
    assign d_arready[g] = (sel == g) && s_arready;
    assign d_rvalid[g]  = (sel == g) && s_rvalid;
    axi_sram_pattern_tester #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_DATA_WIDTH (DW),
      .ADDR_LAST      ((g == 0) ? 10'h00F : (g == 1) ? 10'h000 : 10'h3FF),
      .PATTERN_SEED   (8'hA5)
    ) u_dut (
      .i_axi_clk       (clk),
      .i_axi_reset     (rst),
      .i_start         (d_start[g]),
      .o_busy          (d_busy[g]),
      .o_done          (d_done[g]),
      .o_pass          (d_pass[g]),
      .o_fail_addr     (d_fail_addr[g]),
      .o_fail_expected (d_fail_exp[g]),
      .o_fail_actual   (d_fail_act[g]),
      .o_axi_awaddr    (d_awaddr[g]),
      .o_axi_awvalid   (d_awvalid[g]),
      .i_axi_awready   (d_awready[g]),
      .o_axi_wdata     (d_wdata[g]),
      .o_axi_wstrb     (d_wstrb[g]),
      .o_axi_wvalid    (d_wvalid[g]),
      .i_axi_wready    (d_wready[g]),
      .i_axi_bresp     (s_bresp),
      .i_axi_bvalid    (d_bvalid[g]),
      .o_axi_bready    (d_bready[g]),
      .o_axi_araddr    (d_araddr[g]),
      .o_axi_arvalid   (d_arvalid[g]),
      .i_axi_arready   (d_arready[g]),
      .i_axi_rdata     (s_rdata),
      .i_axi_rresp     (s_rresp),
      .i_axi_rvalid    (d_rvalid[g]),
      .o_axi_rready    (d_rready[g])
    );
  end

  always_comb begin
    s_awvalid = d_awvalid[sel];
    s_awaddr  = d_awaddr[sel];
    s_wvalid  = d_wvalid[sel];
    s_wdata   = d_wdata[sel];
    s_wstrb   = d_wstrb[sel];
    s_bready  = d_bready[sel];
    s_arvalid = d_arvalid[sel];
    s_araddr  = d_araddr[sel];
    s_rready  = d_rready[sel];
  end

  // SRAM slave model with configurable ready stalls and error injection
  logic [DW-1:0] mem [1<<AW];
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  int aw_wait, w_wait, ar_wait;
  int aw_stall = 0, w_stall = 0, ar_stall = 0;
  int bresp_err_addr = -1, rresp_err_addr = -1, corrupt_addr = -1;

  assign s_awready = s_awvalid && !aw_got && (aw_wait >= aw_stall);
  assign s_wready  = s_wvalid  && !w_got  && (w_wait  >= w_stall);
  assign s_arready = s_arvalid && !s_rvalid && (ar_wait >= ar_stall);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= '0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_got <= 1'b1; aw_a <= s_awaddr; aw_wait <= 0;
      end else if (s_awvalid && !aw_got) aw_wait <= aw_wait + 1;
      if (s_wvalid && s_wready) begin
        w_got <= 1'b1; w_d <= s_wdata; w_wait <= 0;
      end else if (s_wvalid && !w_got) w_wait <= w_wait + 1;
      if (aw_got && w_got && !s_bvalid) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (int'(aw_a) == bresp_err_addr) ? 2'b10 : 2'b00;
        mem[aw_a] <= w_d;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (int'(s_araddr) == corrupt_addr) ? 8'hFF : mem[s_araddr];
        s_rresp  <= (int'(s_araddr) == rresp_err_addr) ? 2'b10 : 2'b00;
        ar_wait  <= 0;
      end else if (s_arvalid) ar_wait <= ar_wait + 1;
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
  end

  // Handshake logs (never cleared; tests work from a base index)
  int n_aw = 0, n_w = 0, n_ar = 0, n_bad_strb = 0;
  logic [AW-1:0] awlog[$], arlog[$];
  logic [DW-1:0] wlog[$], rlog[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (s_awvalid && s_awready) begin n_aw++; awlog.push_back(s_awaddr); end
      if (s_wvalid && s_wready) begin
        n_w++; wlog.push_back(s_wdata);
        if (s_wstrb !== 1'b1) n_bad_strb++;
      end
      if (s_arvalid && s_arready) begin n_ar++; arlog.push_back(s_araddr); end
      if (s_rvalid && s_rready) rlog.push_back(s_rdata);
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_word(input int a);
`ifdef AXI_SRAM_PATTERN_TESTER_LFSR_EN
    logic [DW-1:0] s = 8'hA5;
    for (int i = 0; i < a; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    return s;
`else
    logic [DW-1:0] v = a[DW-1:0];
    return v ^ 8'hA5;
`endif
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!d_done[sel] && n < budget) begin @(negedge clk); n++; end
    chk(tag, 32'(d_done[sel]), 32'd1);
  endtask

  function automatic logic [31:0] ctl_vec(input int k);
    return {24'd0, d_busy[k], d_done[k], d_pass[k], d_awvalid[k],
            d_wvalid[k], d_bready[k], d_arvalid[k], d_rready[k]};
  endfunction

  initial begin
    int base_aw, base_w, base_ar, base_r, errs, n;
    bit seen4;

    repeat (3) @(negedge clk);
    chk("rst_ctl",       ctl_vec(0), 32'd0);
    chk("rst_fail_addr", 32'(d_fail_addr[0]), 32'd0);
    chk("rst_awaddr",    32'(d_awaddr[0]), 32'd0);
    chk("rst_wdata",     32'(d_wdata[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 16 words, AW/W handshakes in different cycles, start while busy ignored
    sel = 0; aw_stall = 0; w_stall = 1; ar_stall = 1;
    base_aw = n_aw; base_ar = n_ar;
    pulse_start();
    chk("t1_busy", 32'(d_busy[0]), 32'd1);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(200, "t1_done");
    chk("t1_pass",   32'(d_pass[0]), 32'd1);
    chk("t1_busy_lo", 32'(d_busy[0]), 32'd0);
    chk("t1_mem5",   32'(mem[5]), 32'(exp_word(5)));
    chk("t1_n_aw",   32'(n_aw - base_aw), 32'd16);
    chk("t1_n_ar",   32'(n_ar - base_ar), 32'd16);

    // 2: ADDR_LAST = 0, exactly one beat each way
    sel = 1; aw_stall = 0; w_stall = 0; ar_stall = 0;
    base_aw = n_aw; base_w = n_w; base_ar = n_ar;
    pulse_start();
    wait_done(50, "t2_done");
    chk("t2_pass", 32'(d_pass[1]), 32'd1);
    chk("t2_n_aw", 32'(n_aw - base_aw), 32'd1);
    chk("t2_n_w",  32'(n_w - base_w), 32'd1);
    chk("t2_n_ar", 32'(n_ar - base_ar), 32'd1);
    chk("t2_mem0", 32'(mem[0]), 32'(exp_word(0)));

    // 3: corrupted word 3 on readback
    sel = 0; corrupt_addr = 3;
    base_ar = n_ar;
    pulse_start();
    wait_done(200, "t3_done");
    chk("t3_pass",     32'(d_pass[0]), 32'd0);
    chk("t3_fail_addr", 32'(d_fail_addr[0]), 32'd3);
    chk("t3_fail_exp", 32'(d_fail_exp[0]), 32'(exp_word(3)));
    chk("t3_fail_act", 32'(d_fail_act[0]), 32'hFF);
    seen4 = 1'b0;
    for (int i = base_ar; i < arlog.size(); i++) if (arlog[i] == 10'd4) seen4 = 1'b1;
    chk("t3_no_ar4", 32'(seen4), 32'd0);
    corrupt_addr = -1;

    // 4: SLVERR on read of word 2, then rerun from address 0
    rresp_err_addr = 2;
    pulse_start();
    wait_done(200, "t4_done");
    chk("t4_pass",      32'(d_pass[0]), 32'd0);
    chk("t4_fail_addr", 32'(d_fail_addr[0]), 32'd2);
    chk("t4_fail_exp",  32'(d_fail_exp[0]), 32'(exp_word(2)));
    chk("t4_fail_act",  32'(d_fail_act[0]), 32'(exp_word(2)));
    rresp_err_addr = -1;
    base_aw = n_aw;
    pulse_start();
    chk("t4_done_clr", 32'(d_done[0]), 32'd0);
    wait_done(200, "t4_rerun_done");
    chk("t4_rerun_pass",  32'(d_pass[0]), 32'd1);
    chk("t4_rerun_addr0", 32'(awlog[base_aw]), 32'd0);
    chk("t4_rerun_n_aw",  32'(n_aw - base_aw), 32'd16);

    // write-response error on word 7: fail_actual reads zero, no reads issued
    bresp_err_addr = 7;
    base_ar = n_ar;
    pulse_start();
    wait_done(200, "tb_done");
    chk("tb_pass",      32'(d_pass[0]), 32'd0);
    chk("tb_fail_addr", 32'(d_fail_addr[0]), 32'd7);
    chk("tb_fail_exp",  32'(d_fail_exp[0]), 32'(exp_word(7)));
    chk("tb_fail_act",  32'(d_fail_act[0]), 32'd0);
    chk("tb_n_ar",      32'(n_ar - base_ar), 32'd0);
    bresp_err_addr = -1;

    // 5: reset while in RD_DATA
    pulse_start();
    n = 0;
    while (!(d_rready[0] && !d_arvalid[0]) && n < 300) begin @(negedge clk); n++; end
    chk("t5_reach_rd", 32'(d_rready[0] && !d_arvalid[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_ctl",       ctl_vec(0), 32'd0);
    chk("t5_fail_addr", 32'(d_fail_addr[0]), 32'd0);
    chk("t5_awaddr",    32'(d_awaddr[0]), 32'd0);
    pulse_start();
    wait_done(200, "t5_done");
    chk("t5_pass", 32'(d_pass[0]), 32'd1);

    // 6: full 1024-word range, write and read sequences must agree
    sel = 2;
    base_w = wlog.size(); base_r = rlog.size();
    pulse_start();
    wait_done(20000, "t6_done");
    chk("t6_pass", 32'(d_pass[2]), 32'd1);
    chk("t6_n_w",  32'(wlog.size() - base_w), 32'd1024);
    chk("t6_n_r",  32'(rlog.size() - base_r), 32'd1024);
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (base_w + i >= wlog.size() || base_r + i >= rlog.size()) errs++;
      else if (wlog[base_w + i] != rlog[base_r + i] || wlog[base_w + i] != exp_word(i)) errs++;
    end
    chk("t6_seq", 32'(errs), 32'd0);
    chk("wstrb",  32'(n_bad_strb), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
